// File: rtl/demux_1to4_stream_pkg.sv
// Shared types for the 1-to-4 stream demultiplexer.
//   NUM_PORTS  : number of output streams
//   port_sel_t : 2-bit destination select
//   state_t    : packet framing state (IDLE = no packet open, PKT = packet open)
package demux_pkg;
  localparam int NUM_PORTS = 4;
  typedef logic [1:0] port_sel_t;
  typedef enum logic {IDLE = 1'b0, PKT = 1'b1} state_t;
endpackage

// File: rtl/demux_1to4_stream_if.sv
// Stream bundle for demux_1to4_stream: one input stream, four output streams.
//   in_data/in_sel/in_last/in_valid -> in_ready : upstream beat + destination
//   out_data[k]/out_last[k]/out_valid[k] <- out_ready[k] : per-port downstream
//   out_data is packed so port k sits at bits [k*DATA_W +: DATA_W].
// master = stream source/sink side, slave = demux side.
interface demux_1to4_stream_if #(parameter int DATA_W = 8);
  import demux_pkg::*;
  logic [DATA_W-1:0]                 in_data;
  port_sel_t                         in_sel;
  logic                              in_last;
  logic                              in_valid;
  logic                              in_ready;
  logic [NUM_PORTS-1:0][DATA_W-1:0]  out_data;
  logic [NUM_PORTS-1:0]              out_last;
  logic [NUM_PORTS-1:0]              out_valid;
  logic [NUM_PORTS-1:0]              out_ready;

  modport master (
    output in_data, in_sel, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_last, out_valid
  );
  modport slave (
    input  in_data, in_sel, in_last, in_valid, out_ready,
    output in_ready, out_data, out_last, out_valid
  );
endinterface

// File: rtl/demux_1to4_stream_stage.sv
// stream_reg_stage: one-entry valid/ready register carrying data, last and
// destination port. Fills and drains in the same cycle for full throughput.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : upstream handshake; in_data/in_last/in_port payload
//   full                : stage holds a beat
//   q_data/q_last/q_port: held beat
//   q_ready             : ready of the downstream port the held beat targets
module stream_reg_stage
  import demux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  port_sel_t         in_port,
  output logic              full,
  output logic [DATA_W-1:0] q_data,
  output logic              q_last,
  output port_sel_t         q_port,
  input  logic              q_ready
);
  // Accept when empty, or when the held beat leaves on this same edge.
  assign in_ready = !full || q_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      full   <= 1'b0;
      q_data <= '0;
      q_last <= 1'b0;
      q_port <= '0;
    end else if (in_valid && in_ready) begin
      full   <= 1'b1;
      q_data <= in_data;
      q_last <= in_last;
      q_port <= in_port;
    end else if (full && q_ready) begin
      full   <= 1'b0;
    end
  end
endmodule

// File: rtl/demux_1to4_stream.sv
// demux_1to4_stream: routes whole packets from one valid/ready stream to one
// of four output streams. The select is sampled on a packet's first beat and
// held until its last beat; output goes through one register stage.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : demux_1to4_stream_if.slave (input stream + 4 output streams)
//   pkt_count : (only with DEMUX_PKT_COUNT_EN) 16-bit per-port count of
//               drained last beats, port k at [k*16 +: 16], wraps at 16'hFFFF
module demux_1to4_stream
  import demux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  demux_1to4_stream_if.slave            bus
`ifdef DEMUX_PKT_COUNT_EN
  ,
  output logic [NUM_PORTS-1:0][15:0]    pkt_count
`endif
);
  state_t            state, state_n;
  port_sel_t         sel_q, sel_n;
  port_sel_t         route_sel;
  logic              accept;
  logic              st_full, st_last;
  logic [DATA_W-1:0] st_data;
  port_sel_t         st_port;

  // First beat routes on the live select; later beats use the latched one.
  assign route_sel = (state == IDLE) ? bus.in_sel : sel_q;
  assign accept    = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel_q <= '0;
    end else begin
      state <= state_n;
      sel_q <= sel_n;
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = sel_q;
    case (state)
      IDLE: if (accept) begin
        sel_n = bus.in_sel;
        if (!bus.in_last) state_n = PKT;
      end
      PKT: if (accept && bus.in_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  stream_reg_stage #(.DATA_W(DATA_W)) u_stage (
    .clk      (clk),
    .rst      (rst),
    .in_valid (bus.in_valid),
    .in_ready (bus.in_ready),
    .in_data  (bus.in_data),
    .in_last  (bus.in_last),
    .in_port  (route_sel),
    .full     (st_full),
    .q_data   (st_data),
    .q_last   (st_last),
    .q_port   (st_port),
    .q_ready  (bus.out_ready[st_port])
  );

  // Fan-out: only the held beat's port sees valid/data/last; others read 0.
  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    assign bus.out_valid[k] = st_full && (st_port == port_sel_t'(k));
    assign bus.out_data[k]  = bus.out_valid[k] ? st_data : '0;
    assign bus.out_last[k]  = bus.out_valid[k] && st_last;
`ifdef DEMUX_PKT_COUNT_EN
    always_ff @(posedge clk) begin
      if (rst)
        pkt_count[k] <= '0;
      else if (bus.out_valid[k] && bus.out_ready[k] && bus.out_last[k])
        pkt_count[k] <= pkt_count[k] + 16'd1;
    end
`endif
  end
endmodule

// File: tb/tb_demux_1to4_stream.sv
// Directed testbench for demux_1to4_stream. Inputs change 1ns after the
// rising edge; outputs are checked after that settle time.
module tb_demux_1to4_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  demux_1to4_stream_if #(.DATA_W(8)) bus ();
`ifdef DEMUX_PKT_COUNT_EN
  logic [3:0][15:0] pkt_count;
`endif

  demux_1to4_stream #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave)
`ifdef DEMUX_PKT_COUNT_EN
    ,
    .pkt_count (pkt_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d, input logic l);
    bus.in_valid = v;
    bus.in_sel   = s;
    bus.in_data  = d;
    bus.in_last  = l;
  endtask

  task automatic test_reset();
    drive(1'b0, 2'b00, 8'h00, 1'b0);
    bus.out_ready = 4'b1111;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    n_cmp++; if (bus.out_valid !== 4'b0000) begin n_bad++; $display("FAIL reset_valid got=%b exp=0000", bus.out_valid); end
    n_cmp++; if (bus.out_last !== 4'b0000) begin n_bad++; $display("FAIL reset_last got=%b exp=0000", bus.out_last); end
    n_cmp++; if (bus.out_data !== 32'h0) begin n_bad++; $display("FAIL reset_data got=%h exp=0", bus.out_data); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_reset_mid_packet();
    bus.out_ready = 4'b1111;
    drive(1'b1, 2'b10, 8'h51, 1'b0);
    step();
    n_cmp++; if (bus.out_valid !== 4'b0100 || bus.out_data !== 32'h0051_0000) begin n_bad++; $display("FAIL rmid_beat0 got=%b/%h exp=0100/00510000", bus.out_valid, bus.out_data); end
    drive(1'b1, 2'b00, 8'h52, 1'b0);
    step();
    n_cmp++; if (bus.out_valid !== 4'b0100 || bus.out_data !== 32'h0052_0000) begin n_bad++; $display("FAIL rmid_beat1 got=%b/%h exp=0100/00520000", bus.out_valid, bus.out_data); end
    drive(1'b0, 2'b00, 8'h00, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (bus.out_valid !== 4'b0000) begin n_bad++; $display("FAIL rmid_valid got=%b exp=0000", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_ready got=%b exp=1", bus.in_ready); end
    // New packet must route on its own select, not the dropped packet's.
    drive(1'b1, 2'b01, 8'h61, 1'b1);
    step();
    n_cmp++; if (bus.out_valid !== 4'b0010 || bus.out_data !== 32'h0000_6100 || bus.out_last !== 4'b0010) begin n_bad++; $display("FAIL rmid_newpkt got=%b/%h/%b exp=0010/00006100/0010", bus.out_valid, bus.out_data, bus.out_last); end
    drive(1'b0, 2'b00, 8'h00, 1'b0);
    step();
    n_cmp++; if (bus.out_valid !== 4'b0000) begin n_bad++; $display("FAIL rmid_drain got=%b exp=0000", bus.out_valid); end
  endtask

  task automatic test_single_beat();
    logic [31:0] exp_d;
    logic [3:0]  exp_v;
    bus.out_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), 8'(8'hA0 + i), 1'b1);
      step();
      exp_v = 4'b0001 << i;
      exp_d = 32'(8'hA0 + i) << (8 * i);
      n_cmp++; if (bus.out_valid !== exp_v || bus.out_data !== exp_d || bus.out_last !== exp_v) begin n_bad++; $display("FAIL single_p%0d got=%b/%h/%b exp=%b/%h/%b", i, bus.out_valid, bus.out_data, bus.out_last, exp_v, exp_d, exp_v); end
    end
    drive(1'b0, 2'b00, 8'h00, 1'b0);
    step();
    n_cmp++; if (bus.out_valid !== 4'b0000) begin n_bad++; $display("FAIL single_drain got=%b exp=0000", bus.out_valid); end
  endtask

  task automatic test_select_held();
    bus.out_ready = 4'b1111;
    drive(1'b1, 2'b11, 8'h10, 1'b0);
    step();
    n_cmp++; if (bus.out_valid !== 4'b1000 || bus.out_data !== 32'h1000_0000 || bus.out_last !== 4'b0000) begin n_bad++; $display("FAIL held_b0 got=%b/%h/%b exp=1000/10000000/0000", bus.out_valid, bus.out_data, bus.out_last); end
    drive(1'b1, 2'b00, 8'h11, 1'b0);
    step();
    n_cmp++; if (bus.out_valid !== 4'b1000 || bus.out_data !== 32'h1100_0000 || bus.out_last !== 4'b0000) begin n_bad++; $display("FAIL held_b1 got=%b/%h/%b exp=1000/11000000/0000", bus.out_valid, bus.out_data, bus.out_last); end
    drive(1'b1, 2'b00, 8'h12, 1'b1);
    step();
    n_cmp++; if (bus.out_valid !== 4'b1000 || bus.out_data !== 32'h1200_0000 || bus.out_last !== 4'b1000) begin n_bad++; $display("FAIL held_b2 got=%b/%h/%b exp=1000/12000000/1000", bus.out_valid, bus.out_data, bus.out_last); end
    drive(1'b0, 2'b00, 8'h00, 1'b0);
    step();
    n_cmp++; if (bus.out_valid !== 4'b0000) begin n_bad++; $display("FAIL held_drain got=%b exp=0000", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 4'b1101;
    drive(1'b1, 2'b01, 8'h11, 1'b0);
    step();
    drive(1'b1, 2'b01, 8'h22, 1'b1);
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 4'b0010 || bus.out_data !== 32'h0000_1100) begin n_bad++; $display("FAIL bp_hold%0d got=%b/%b/%h exp=0/0010/00001100", i, bus.in_ready, bus.out_valid, bus.out_data); end
      if (i < 4) step();
    end
    bus.out_ready = 4'b1111;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready got=%b exp=1", bus.in_ready); end
    step();
    n_cmp++; if (bus.out_valid !== 4'b0010 || bus.out_data !== 32'h0000_2200 || bus.out_last !== 4'b0010) begin n_bad++; $display("FAIL bp_second got=%b/%h/%b exp=0010/00002200/0010", bus.out_valid, bus.out_data, bus.out_last); end
    drive(1'b0, 2'b00, 8'h00, 1'b0);
    step();
    n_cmp++; if (bus.out_valid !== 4'b0000) begin n_bad++; $display("FAIL bp_drain got=%b exp=0000", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 4'b1111;
    drive(1'b1, 2'b00, 8'h01, 1'b0);
    step();
    n_cmp++; if (bus.out_valid !== 4'b0001 || bus.out_data !== 32'h0000_0001) begin n_bad++; $display("FAIL b2b_b0 got=%b/%h exp=0001/00000001", bus.out_valid, bus.out_data); end
    drive(1'b1, 2'b00, 8'h02, 1'b1);
    step();
    n_cmp++; if (bus.out_valid !== 4'b0001 || bus.out_data !== 32'h0000_0002 || bus.out_last !== 4'b0001) begin n_bad++; $display("FAIL b2b_b1 got=%b/%h/%b exp=0001/00000002/0001", bus.out_valid, bus.out_data, bus.out_last); end
    drive(1'b1, 2'b10, 8'h03, 1'b1);
    step();
    n_cmp++; if (bus.out_valid !== 4'b0100 || bus.out_data !== 32'h0003_0000 || bus.out_last !== 4'b0100) begin n_bad++; $display("FAIL b2b_b2 got=%b/%h/%b exp=0100/00030000/0100", bus.out_valid, bus.out_data, bus.out_last); end
    drive(1'b0, 2'b00, 8'h00, 1'b0);
    step();
    n_cmp++; if (bus.out_valid !== 4'b0000) begin n_bad++; $display("FAIL b2b_drain got=%b exp=0000", bus.out_valid); end
  endtask

`ifdef DEMUX_PKT_COUNT_EN
  task automatic test_pkt_count();
    bus.out_ready = 4'b1111;
    drive(1'b0, 2'b00, 8'h00, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (pkt_count !== 64'h0) begin n_bad++; $display("FAIL cnt_reset got=%h exp=0", pkt_count); end
    for (int i = 0; i < 70000; i++) begin
      drive(1'b1, 2'b01, 8'(i), 1'b1);
      step();
    end
    drive(1'b0, 2'b00, 8'h00, 1'b0);
    step();
    n_cmp++; if (pkt_count[1] !== 16'd4464) begin n_bad++; $display("FAIL cnt_port1 got=%0d exp=4464", pkt_count[1]); end
    n_cmp++; if (pkt_count[0] !== 16'd0 || pkt_count[2] !== 16'd0 || pkt_count[3] !== 16'd0) begin n_bad++; $display("FAIL cnt_others got=%h exp=0 on ports 0,2,3", pkt_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid_packet();
    test_single_beat();
    test_select_held();
    test_backpressure();
    test_back_to_back();
`ifdef DEMUX_PKT_COUNT_EN
    test_pkt_count();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
